// File: rtl/buffout_tx.sv
// buffout_tx: output byte FIFO with backpressured strobe drain and end-of-file terminator.
module buffout_tx #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           ADDR_WIDTH = 7,
   parameter logic [DATA_WIDTH-1:0] EOF_B0     = 8'h00,
   parameter logic [DATA_WIDTH-1:0] EOF_B1     = 8'h80
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wre,
   input  logic                  fin,
   input  logic                  dst_full,
   output logic [DATA_WIDTH-1:0] q_out,
   output logic                  wr_out,
   output logic [ADDR_WIDTH-1:0] count,
   output logic                  full,
   output logic                  empt,
   output logic                  ovf,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {RUN, TERM0, TERM1, DONE} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   ram [DEPTH];
   logic [ADDR_WIDTH-1:0]   ptri;
   logic [ADDR_WIDTH-1:0]   ptro;
   logic                    fin_pend;
   logic                    push;
   logic                    pop;

   // Occupancy flags; one slot is kept free so the count fits ADDR_WIDTH bits.
   assign full = (count == {ADDR_WIDTH{1'b1}});
   assign empt = (count == '0);

   // Accepted write and FIFO pop for this cycle; popping only happens in RUN.
   assign push = wre && !full;
   assign pop  = (state == RUN) && !dst_full && (count != '0);

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      if (push) ram[ptri] <= data;
   end

   // Pointers, occupancy, overflow flag and the drain/terminator FSM.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= RUN;
         ptri     <= '0;
         ptro     <= '0;
         count    <= '0;
         q_out    <= '0;
         wr_out   <= 1'b0;
         ovf      <= 1'b0;
         fin_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_out <= 1'b0;
         if (wre && full) ovf <= 1'b1;
         if (push) ptri <= ptri + ADDR_WIDTH'(1);
         count <= count + ADDR_WIDTH'(push) - ADDR_WIDTH'(pop);
         case (state)
            RUN: begin
               if (fin) fin_pend <= 1'b1;
               if (pop) begin
                  q_out  <= ram[ptro];
                  wr_out <= 1'b1;
                  ptro   <= ptro + ADDR_WIDTH'(1);
                  // Last pending byte leaves now: start the terminator right behind it.
                  if (fin_pend && (count == ADDR_WIDTH'(1)) && !push) begin
                     state <= TERM0;
                     busy  <= 1'b1;
                  end
               end else if (fin_pend && (count == '0) && !dst_full) begin
                  state <= TERM0;
                  busy  <= 1'b1;
               end
            end
            TERM0: begin
               if (!dst_full) begin
                  q_out  <= EOF_B0;
                  wr_out <= 1'b1;
                  state  <= TERM1;
               end
            end
            TERM1: begin
               if (!dst_full) begin
                  q_out    <= EOF_B1;
                  wr_out   <= 1'b1;
                  fin_pend <= 1'b0;
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            DONE: begin
               if (count != '0) begin
                  state <= RUN;
                  done  <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
